gray_conv_arbiter: RTL and testbench

Shares one WIDTH-bit binary-to-Gray converter between two requesters. A round-robin arbiter grants one request per cycle, converts the granted binary word, and holds the Gray result with its requester ID in a single-entry output register under a valid/ready handshake. The block sits between the binary counter/address sources and the Gray-coded consumers, such as CDC pointer paths and encoder outputs.

---
 rtl/gray_arb_pkg.sv | 14 +
 rtl/bin2gray_conv.sv | 11 +
 rtl/gray_conv_arbiter.sv | 94 +++++++++
 tb/tb_gray_conv_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_arb_pkg.sv
// Shared types and constants for the Gray-converter arbiter slice.
package gray_arb_pkg;

  localparam int unsigned DEF_WIDTH = 3;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  typedef logic [0:0] req_id_t;

endpackage

// File: rtl/bin2gray_conv.sv
// Purely combinational binary-to-Gray converter.
module bin2gray_conv #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin sharing of one binary-to-Gray converter between two requesters,
// with a single-entry valid/ready result register. Define GRAY_ARB_CNT_EN for grant counters.
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req0_valid_in,
  input  logic [WIDTH-1:0] req0_bin_in,
  output logic             req0_ready_out,
  input  logic             req1_valid_in,
  input  logic [WIDTH-1:0] req1_bin_in,
  output logic             req1_ready_out,
  output logic             res_valid_out,
  output logic [WIDTH-1:0] res_gray_out,
  output logic             res_id_out,
  input  logic             res_ready_in
`ifdef GRAY_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0_out,
  output logic [CNT_W-1:0] grant_cnt1_out
`endif
);

  out_state_e       state, state_nxt;
  req_id_t          prio;
  req_id_t          sel_id;
  logic             grant_ok;
  logic             grant;
  logic [WIDTH-1:0] mux_bin;
  logic [WIDTH-1:0] conv_gray;

  // Requester 1 wins only when it is alone or holds priority.
  assign sel_id   = req_id_t'(req1_valid_in && (!req0_valid_in || prio == req_id_t'(1)));
  assign grant_ok = !rst_in && ((state == EMPTY) || res_ready_in);

  assign req0_ready_out = grant_ok && req0_valid_in && (sel_id == req_id_t'(0));
  assign req1_ready_out = grant_ok && req1_valid_in && (sel_id == req_id_t'(1));
  assign grant          = req0_ready_out || req1_ready_out;

  assign mux_bin = (sel_id == req_id_t'(1)) ? req1_bin_in : req0_bin_in;

  bin2gray_conv #(.WIDTH(WIDTH)) u_conv (
    .bin  (mux_bin),
    .gray (conv_gray)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= EMPTY;
    else        state <= state_nxt;
  end

  // A grant always refills the register, so FULL only drains when nothing new arrives.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (res_ready_in && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign res_valid_out = (state == FULL);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      res_gray_out <= '0;
      res_id_out   <= 1'b0;
      prio         <= req_id_t'(0);
    end else if (grant) begin
      res_gray_out <= conv_gray;
      res_id_out   <= sel_id[0];
      prio         <= ~sel_id;
    end
  end

`ifdef GRAY_ARB_CNT_EN
  // Saturating per-requester accepted-transfer counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      grant_cnt0_out <= '0;
      grant_cnt1_out <= '0;
    end else begin
      if (req0_ready_out && (grant_cnt0_out != '1))
        grant_cnt0_out <= grant_cnt0_out + CNT_W'(1);
      if (req1_ready_out && (grant_cnt1_out != '1))
        grant_cnt1_out <= grant_cnt1_out + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter (WIDTH = 3); GRAY_ARB_CNT_EN adds the counter test.
module tb_gray_conv_arbiter;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       req0_valid_in, req1_valid_in;
  logic [2:0] req0_bin_in, req1_bin_in;
  logic       req0_ready_out, req1_ready_out;
  logic       res_valid_out;
  logic [2:0] res_gray_out;
  logic       res_id_out;
  logic       res_ready_in;
`ifdef GRAY_ARB_CNT_EN
  logic [7:0] grant_cnt0_out, grant_cnt1_out;
`endif

  int checks = 0;
  int errors = 0;

  // Hand-computed Gray codes for the words currently driven on each requester.
  logic [2:0] exp0_gray, exp1_gray;

  logic [3:0] sb_q[$];
  logic       m_full = 1'b0;
  logic       m_prio = 1'b0;
  int         m_cnt0 = 0;
  int         m_cnt1 = 0;

  always #5 clk_in = ~clk_in;

  gray_conv_arbiter #(.WIDTH(3)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .req0_valid_in  (req0_valid_in),
    .req0_bin_in    (req0_bin_in),
    .req0_ready_out (req0_ready_out),
    .req1_valid_in  (req1_valid_in),
    .req1_bin_in    (req1_bin_in),
    .req1_ready_out (req1_ready_out),
    .res_valid_out  (res_valid_out),
    .res_gray_out   (res_gray_out),
    .res_id_out     (res_id_out),
    .res_ready_in   (res_ready_in)
`ifdef GRAY_ARB_CNT_EN
    ,
    .grant_cnt0_out (grant_cnt0_out),
    .grant_cnt1_out (grant_cnt1_out)
`endif
  );

  // Request-side model: predicts readies, pushes expected results.
  always @(negedge clk_in) begin
    logic allow, e0, e1;
    allow = !rst_in && (!m_full || res_ready_in);
    e0 = allow && req0_valid_in && (!req1_valid_in || !m_prio);
    e1 = allow && req1_valid_in && (!req0_valid_in || m_prio);
    checks++;
    if (req0_ready_out !== e0 || req1_ready_out !== e1) begin
      errors++;
      $display("FAIL ready @%0t: got r0=%b r1=%b expected r0=%b r1=%b",
               $time, req0_ready_out, req1_ready_out, e0, e1);
    end
    checks++;
    if (res_valid_out !== m_full) begin
      errors++;
      $display("FAIL res_valid @%0t: got %b expected %b", $time, res_valid_out, m_full);
    end
    if (rst_in) begin
      sb_q.delete();
      m_full = 1'b0;
      m_prio = 1'b0;
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else if (e0 || e1) begin
      sb_q.push_back(e0 ? {exp0_gray, 1'b0} : {exp1_gray, 1'b1});
      m_full = 1'b1;
      m_prio = e0;
      if (e0 && m_cnt0 < 255) m_cnt0++;
      if (e1 && m_cnt1 < 255) m_cnt1++;
    end else if (m_full && res_ready_in) begin
      m_full = 1'b0;
    end
  end

  // Result-side monitor: every presented result must match the queue head.
  always @(negedge clk_in) begin
    if (!rst_in && res_valid_out === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL result @%0t: got gray=%b id=%b with no expected entry",
                 $time, res_gray_out, res_id_out);
      end else begin
        if ({res_gray_out, res_id_out} !== sb_q[0]) begin
          errors++;
          $display("FAIL result @%0t: got gray=%b id=%b expected gray=%b id=%b",
                   $time, res_gray_out, res_id_out, sb_q[0][3:1], sb_q[0][0]);
        end
        if (res_ready_in) void'(sb_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  logic [2:0] gray_tbl [8];

  initial begin
    gray_tbl = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    // Reset with both requesters pushing.
    rst_in = 1'b1; res_ready_in = 1'b1;
    req0_valid_in = 1'b1; req0_bin_in = 3'b101; exp0_gray = 3'b111;
    req1_valid_in = 1'b1; req1_bin_in = 3'b010; exp1_gray = 3'b011;
    cyc(); cyc();
    check_bit("reset_gray_zero", (res_gray_out == 3'b000), 1'b1);
    check_bit("reset_id_zero", res_id_out, 1'b0);

    // Contention: first grant goes to requester 0, then alternates.
    rst_in = 1'b0;
    @(negedge clk_in);
    check_bit("first_grant_req0", req0_ready_out, 1'b1);
    for (int i = 0; i < 4; i++) cyc();

    // Single requester sweeping 0..7.
    req1_valid_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req0_bin_in = 3'(i);
      exp0_gray   = gray_tbl[i];
      cyc();
    end

    // Backpressure while FULL, then release with a same-cycle reload.
    res_ready_in = 1'b0;
    req0_valid_in = 1'b1; req0_bin_in = 3'b110; exp0_gray = 3'b101;
    req1_valid_in = 1'b1; req1_bin_in = 3'b011; exp1_gray = 3'b010;
    for (int i = 0; i < 4; i++) cyc();
    res_ready_in = 1'b1;
    @(negedge clk_in);
    check_bit("release_grants_req1", req1_ready_out, 1'b1);
    cyc(); cyc();
    req0_valid_in = 1'b0; req1_valid_in = 1'b0;
    cyc(); cyc();

    // Mid-operation reset discards the held result and clears priority.
    res_ready_in = 1'b0;
    req0_valid_in = 1'b1; req0_bin_in = 3'b100; exp0_gray = 3'b110;
    req1_valid_in = 1'b1; req1_bin_in = 3'b001; exp1_gray = 3'b001;
    cyc(); cyc();
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
    req0_valid_in = 1'b0; req1_valid_in = 1'b0; res_ready_in = 1'b1;
    @(negedge clk_in);
    check_bit("post_reset_valid", res_valid_out, 1'b0);
    cyc();
    req0_valid_in = 1'b1; req1_valid_in = 1'b1;
    @(negedge clk_in);
    check_bit("post_reset_prio_req0", req0_ready_out, 1'b1);
    cyc();
    req0_valid_in = 1'b0; req1_valid_in = 1'b0;
    cyc(); cyc();

`ifdef GRAY_ARB_CNT_EN
    // Saturation of requester 1 counter.
    req1_valid_in = 1'b1; req1_bin_in = 3'b111; exp1_gray = 3'b100;
    for (int i = 0; i < 300; i++) cyc();
    req1_valid_in = 1'b0;
    cyc(); cyc();
    checks++;
    if (grant_cnt1_out !== 8'd255) begin
      errors++;
      $display("FAIL grant_cnt1: got %0d expected 255", grant_cnt1_out);
    end
    checks++;
    if (grant_cnt0_out !== 8'(m_cnt0)) begin
      errors++;
      $display("FAIL grant_cnt0: got %0d expected %0d", grant_cnt0_out, m_cnt0);
    end
`endif

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
